// File: rtl/crtc_mode_loader.sv
// Loads a video mode from the mode table ROM into the CRTC register bank:
// timing regs 0-9, then N PLL entries (regs 12/10/11 + trigger on reg 13).
module crtc_mode_loader #(
   parameter int unsigned NUM_MODES = 8,
   parameter int unsigned GUARD     = 2,
   parameter int unsigned TIMEOUT   = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mode,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic [1:0]  crtc_wr,
   output logic [3:0]  crtc_addr,
   output logic [15:0] crtc_din,
   input  logic [15:0] crtc_dout
);

   typedef enum logic [3:0] {
      S_IDLE, S_TIMING, S_COUNT, S_PLL_WORDS, S_PRE_POLL,
      S_TRIG, S_GUARD, S_POLL, S_DONE
   } state_t;

   localparam logic [15:0] LP_TMO_LAST   = 16'(TIMEOUT - 1);
   localparam logic [15:0] LP_GUARD_LAST = 16'(GUARD - 1);
   localparam logic        LP_HAS_GUARD  = (GUARD != 0);

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_mode,  w_mode_nxt;
   logic [4:0]  r_off,   w_off_nxt;
   logic [3:0]  r_cnt,   w_cnt_nxt;
   logic [2:0]  r_n,     w_n_nxt;
   logic [2:0]  r_k,     w_k_nxt;
   logic [15:0] r_tmo,   w_tmo_nxt;
   logic        r_err,   w_err_nxt;

   logic w_pll_busy;
   logic w_mode_ok;
   logic w_unused;

   assign w_pll_busy = crtc_dout[0];
   assign w_unused   = ^crtc_dout[15:1];
   assign w_mode_ok  = (32'(mode) < NUM_MODES);

   assign rom_addr = {r_mode, r_off};
   assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done     = (r_state == S_DONE);
   assign error    = r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_mode  <= '0;
         r_off   <= '0;
         r_cnt   <= '0;
         r_n     <= '0;
         r_k     <= '0;
         r_tmo   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_off   <= w_off_nxt;
         r_cnt   <= w_cnt_nxt;
         r_n     <= w_n_nxt;
         r_k     <= w_k_nxt;
         r_tmo   <= w_tmo_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_off_nxt   = r_off;
      w_cnt_nxt   = r_cnt;
      w_n_nxt     = r_n;
      w_k_nxt     = r_k;
      w_tmo_nxt   = r_tmo;
      w_err_nxt   = r_err;
      crtc_wr     = '0;
      crtc_addr   = '0;
      crtc_din    = '0;

      case (r_state)
         S_IDLE: begin
            if (start && w_mode_ok) begin
               w_mode_nxt  = mode;
               w_off_nxt   = '0;
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b0;
               w_state_nxt = S_TIMING;
            end
         end

         // r_cnt is the fetch slot; the write lags one slot behind the ROM latency
         S_TIMING: begin
            if (r_cnt != 4'd0) begin
               crtc_wr   = 2'b11;
               crtc_addr = r_cnt - 4'd1;
               crtc_din  = rom_data;
            end
            if (r_cnt < 4'd10) w_off_nxt = r_off + 5'd1;
            if (r_cnt == 4'd10) w_state_nxt = S_COUNT;
            else                w_cnt_nxt   = r_cnt + 4'd1;
         end

         S_COUNT: begin
            w_n_nxt = rom_data[2:0];
            w_k_nxt = '0;
            if (rom_data[2:0] == 3'd0) begin
               w_state_nxt = S_DONE;
            end else begin
               w_off_nxt   = 5'd11;
               w_cnt_nxt   = '0;
               w_state_nxt = S_PLL_WORDS;
            end
         end

         S_PLL_WORDS: begin
            case (r_cnt)
               4'd1:    begin crtc_wr = 2'b11; crtc_addr = 4'd12; crtc_din = rom_data; end
               4'd2:    begin crtc_wr = 2'b11; crtc_addr = 4'd10; crtc_din = rom_data; end
               4'd3:    begin crtc_wr = 2'b11; crtc_addr = 4'd11; crtc_din = rom_data; end
               default: ;
            endcase
            if (r_cnt < 4'd2) w_off_nxt = r_off + 5'd1;
            if (r_cnt == 4'd3) begin
               w_tmo_nxt   = '0;
               w_state_nxt = S_PRE_POLL;
            end else begin
               w_cnt_nxt   = r_cnt + 4'd1;
            end
         end

         S_PRE_POLL: begin
            crtc_addr = 4'd13;
            if (!w_pll_busy) begin
               w_state_nxt = S_TRIG;
            end else if (r_tmo == LP_TMO_LAST) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_tmo_nxt   = r_tmo + 16'd1;
            end
         end

         S_TRIG: begin
            crtc_wr     = 2'b01;
            crtc_addr   = 4'd13;
            w_tmo_nxt   = '0;
            w_state_nxt = LP_HAS_GUARD ? S_GUARD : S_POLL;
         end

         // the timeout counter doubles as the guard counter; it is cleared again for POLL
         S_GUARD: begin
            if (r_tmo == LP_GUARD_LAST) begin
               w_tmo_nxt   = '0;
               w_state_nxt = S_POLL;
            end else begin
               w_tmo_nxt   = r_tmo + 16'd1;
            end
         end

         S_POLL: begin
            crtc_addr = 4'd13;
            if (!w_pll_busy) begin
               if (r_k == r_n - 3'd1) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_k_nxt     = r_k + 3'd1;
                  w_off_nxt   = r_off + 5'd1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_PLL_WORDS;
               end
            end else if (r_tmo == LP_TMO_LAST) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_tmo_nxt   = r_tmo + 16'd1;
            end
         end

         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_crtc_mode_loader.sv
// Self-checking bench for crtc_mode_loader: random mode table, PLL busy model,
// expected write trace built from the record layout.
module tb_crtc_mode_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  mode;
   logic        busy, done, error;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [1:0]  crtc_wr;
   logic [3:0]  crtc_addr;
   logic [15:0] crtc_din;
   logic [15:0] crtc_dout;

   crtc_mode_loader #(.NUM_MODES(8), .GUARD(2), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .busy(busy), .done(done), .error(error),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .crtc_wr(crtc_wr), .crtc_addr(crtc_addr), .crtc_din(crtc_din),
      .crtc_dout(crtc_dout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode table ROM, one cycle read latency
   logic [15:0] rom [0:255];
   always @(posedge clk) rom_data <= rom[rom_addr];

   // PLL busy model: busy for busy_len cycles starting one cycle after a trigger
   int   cyc = 0;
   int   pre_until = 0;
   int   post_until = 0;
   int   busy_len = 5;
   bit   stuck_en = 0;
   bit   stuck_hit = 0;
   logic [14:0] noise = '0;
   logic pll_busy;

   assign pll_busy  = (cyc < pre_until) || (cyc < post_until) || stuck_hit;
   assign crtc_dout = {noise, pll_busy};

   always @(posedge clk) begin
      if (crtc_wr == 2'b01 && crtc_addr == 4'd13) begin
         post_until <= cyc + 1 + busy_len;
         if (stuck_en) stuck_hit <= 1'b1;
      end else if (!stuck_en) begin
         stuck_hit <= 1'b0;
      end
      noise <= 15'($urandom);
      cyc   <= cyc + 1;
   end

   // monitor
   int          t1 = -1;
   logic        err_t1;
   logic [7:0]  ra_t1;
   logic        busy_tr [0:63];
   logic [21:0] act_w [$];
   int          act_t [$];
   int          falls [$];
   int          done_cnt = 0;
   int          done_cyc = -1;
   logic        done_err;
   logic        prev_pb = 1'b0;

   always @(negedge clk) begin
      if (t1 < 0 && busy) begin
         t1 = cyc; err_t1 = error; ra_t1 = rom_addr;
      end
      if (t1 >= 0 && (cyc - t1 + 1) < 64) busy_tr[cyc - t1 + 1] = busy;
      if (crtc_wr != 2'b00) begin
         act_w.push_back({crtc_wr, crtc_addr, crtc_din});
         act_t.push_back(cyc);
      end
      if (done) begin
         done_cnt++; done_cyc = cyc; done_err = error;
      end
      if (prev_pb && !pll_busy) falls.push_back(cyc);
      prev_pb = pll_busy;
   end

   // expected write trace straight from the record layout
   task automatic compare(input int m, input int n, input bit stk);
      logic [21:0] e [$];
      int b = m * 32;
      int lim;
      for (int i = 0; i < 10; i++) e.push_back({2'b11, 4'(i), rom[b + i]});
      for (int k = 0; k < n; k++) begin
         e.push_back({2'b11, 4'd12, rom[b + 11 + 3 * k]});
         e.push_back({2'b11, 4'd10, rom[b + 12 + 3 * k]});
         e.push_back({2'b11, 4'd11, rom[b + 13 + 3 * k]});
         e.push_back({2'b01, 4'd13, 16'h0000});
         if (stk) break;
      end
      check($sformatf("m%0d_wr_count", m), 32'(act_w.size()), 32'(e.size()));
      lim = (act_w.size() < e.size()) ? act_w.size() : e.size();
      for (int i = 0; i < lim; i++)
         check($sformatf("m%0d_wr%0d", m, i), 32'(act_w[i]), 32'(e[i]));
   endtask

   task automatic run(input int m, input int n, input bit stk, input int pre,
                      input bit extra, input int blen);
      bit got = 0;
      bit busy_any = 0;
      rom[m * 32 + 10] = {13'($urandom), 3'(n)};
      busy_len = blen;
      stuck_en = stk;
      act_w.delete(); act_t.delete(); falls.delete();
      done_cnt = 0; done_cyc = -1; t1 = -1;
      for (int i = 0; i < 64; i++) busy_tr[i] = 1'b0;
      @(negedge clk);
      pre_until = cyc + pre;
      mode  = 3'(m);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         start = (extra && i == 4);
         if (extra && i == 4) mode = 3'(m + 1);
         if (done) begin
            got = 1;
            if (extra) begin start = 1'b1; mode = 3'(m + 2); end
         end
      end
      check($sformatf("m%0d_done_seen", m), 32'(got), 32'd1);
      @(negedge clk);
      start    = 1'b0;
      stuck_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (busy) busy_any = 1;
      end
      check($sformatf("m%0d_idle_after", m), 32'(busy_any), 32'd0);
      check($sformatf("m%0d_done_pulses", m), 32'(done_cnt), 32'd1);
      check($sformatf("m%0d_done_err", m), 32'(done_err), 32'(stk));
      compare(m, n, stk);
   endtask

   function automatic int trig_time(input int idx);
      return (act_t.size() > idx) ? act_t[idx] : -100;
   endfunction

   function automatic int count_trig();
      int c = 0;
      foreach (act_w[i]) if (act_w[i][21:20] == 2'b01) c++;
      return c;
   endfunction

   initial begin
      int nb;
      bit found;
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      reset = 1'b1; start = 1'b0; mode = '0;
      repeat (2) @(negedge clk);
      check("rst_busy",  32'(busy), 0);
      check("rst_done",  32'(done), 0);
      check("rst_error", 32'(error), 0);
      check("rst_wr",    32'(crtc_wr), 0);
      check("rst_addr",  32'(crtc_addr), 0);
      check("rst_din",   32'(crtc_din), 0);
      check("rst_rom",   32'(rom_addr), 0);
      reset = 1'b0;
      @(negedge clk);

      // timing-only record with exact cycle placement
      for (int i = 0; i < 10; i++) rom[3 * 32 + i] = 16'h0100 + 16'(i);
      run(3, 0, 0, 0, 0, 5);
      check("m3_rom_t1", 32'(ra_t1), 32'({3'd3, 5'd0}));
      for (int i = 0; i < 10; i++)
         check($sformatf("m3_wr%0d_cycle", i), 32'(trig_time(i) - t1 + 1), 32'(i + 2));
      check("m3_done_cycle", 32'(done_cyc - t1 + 1), 32'd13);
      for (int r = 1; r <= 13; r++)
         check($sformatf("m3_busy_T%0d", r), 32'(busy_tr[r]), 32'(r <= 12));

      // two PLL entries, busy 5 cycles after each trigger
      run(1, 2, 0, 0, 0, 5);
      check("m1_triggers", 32'(count_trig()), 32'd2);
      check("m1_done_after_fall", 32'(done_cyc - (falls.size() > 0 ? falls[$] : -100)), 32'd1);

      // PLL already busy before the first entry
      run(5, 1, 0, 26, 0, 5);
      check("m5_trig_after_fall", 32'(trig_time(13) - (falls.size() > 0 ? falls[0] : -100)), 32'd1);

      // PLL stuck busy after the first trigger
      run(6, 3, 1, 0, 0, 5);
      check("m6_tmo_done_cycle", 32'(done_cyc - trig_time(13)), 32'd19);
      check("err_sticky", 32'(error), 32'd1);
      run(2, 1, 0, 0, 0, 5);
      check("err_cleared_T1", 32'(err_t1), 32'd0);
      check("err_after_ok", 32'(error), 32'd0);

      // extra start pulses mid-run and in the DONE cycle
      run(4, 2, 0, 0, 1, 5);

      // reset in the middle of PLL word writes
      rom[7 * 32 + 10] = {13'($urandom), 3'd3};
      act_w.delete(); act_t.delete(); t1 = -1;
      @(negedge clk);
      mode = 3'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (crtc_wr == 2'b11 && crtc_addr == 4'd12) found = 1;
      end
      check("rstmid_reached_pll", 32'(found), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rstmid_busy", 32'(busy), 0);
      check("rstmid_wr",   32'(crtc_wr), 0);
      check("rstmid_addr", 32'(crtc_addr), 0);
      check("rstmid_rom",  32'(rom_addr), 0);
      nb = act_w.size();
      repeat (3) @(negedge clk);
      check("rstmid_no_writes", 32'(act_w.size()), 32'(nb));
      reset = 1'b0;
      run(7, 3, 0, 0, 0, 5);

      // random records and busy lengths
      for (int r = 0; r < 6; r++)
         run($urandom_range(0, 7), $urandom_range(0, 7), 0, 0, 0, $urandom_range(1, 8));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

endmodule
